// File: rtl/lcd_video_out.sv
// rtl/lcd_video_out.sv - LCD raster timing, frame-buffer read request, latency alignment, pixel conversion
// Optional colour-bar source: define LCD_TEST_PATTERN_EN (adds tp_sel input).
module lcd_video_out #(
  parameter int IN_FMT   = 0,
  parameter int IN_W     = 16,
  parameter int OUT_BITS = 8,
  parameter int RD_LAT   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                video_clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CNT_W-1:0]    h_total,
  input  logic [CNT_W-1:0]    h_sync,
  input  logic [CNT_W-1:0]    h_bporch,
  input  logic [CNT_W-1:0]    h_res,
  input  logic [CNT_W-1:0]    v_total,
  input  logic [CNT_W-1:0]    v_sync,
  input  logic [CNT_W-1:0]    v_bporch,
  input  logic [CNT_W-1:0]    v_res,
  input  logic                hs_pol,
  input  logic                vs_pol,
`ifdef LCD_TEST_PATTERN_EN
  input  logic                tp_sel,
`endif
  output logic                fb_rden,
  input  logic [IN_W-1:0]     fb_data,
  input  logic                fb_empty,
  output logic                lcd_hs,
  output logic                lcd_vs,
  output logic                lcd_de,
  output logic [OUT_BITS-1:0] lcd_r,
  output logic [OUT_BITS-1:0] lcd_g,
  output logic [OUT_BITS-1:0] lcd_b,
  output logic                frame_start,
  output logic                cfg_err,
  output logic                underflow,
  input  logic                underflow_clr
);

  localparam int SW = CNT_W + 2;
  // Stage 0 is aligned with fb_rden, stage DL-1 with the captured pixel r_pix.
  localparam int DL = RD_LAT + 2;

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic [CNT_W-1:0] r_h_total, r_h_sync, r_h_bporch, r_h_res;
  logic [CNT_W-1:0] r_v_total, r_v_sync, r_v_bporch, r_v_res;
  logic             r_run, r_cfg_err, r_frame_start;
`ifdef LCD_TEST_PATTERN_EN
  logic             r_tp;
`endif

  logic             w_h_wrap, w_v_wrap, w_load, w_cfg_bad, w_go;
  logic [SW-1:0]    w_h_start, w_h_end, w_v_start, w_v_end;
  logic             w_h_act, w_v_act, w_hs, w_vs, w_de, w_rden;

  logic [2:0]       r_dl [DL];
  logic             r_rden;
  logic [IN_W-1:0]  r_pix;
  logic             r_hs_o, r_vs_o, r_de_o, r_underflow;
  logic [OUT_BITS-1:0] r_r, r_g, r_b;

  logic [7:0]       w_r8, w_g8, w_b8;
  logic [7:0]       w_sr8, w_sg8, w_sb8;

  assign w_h_wrap  = (SW'(r_h_cnt) + SW'(1)) >= SW'(r_h_total);
  assign w_v_wrap  = (SW'(r_v_cnt) + SW'(1)) >= SW'(r_v_total);
  assign w_load    = enable & (~r_run | (w_h_wrap & w_v_wrap));
  assign w_cfg_bad = ((SW'(h_sync) + SW'(h_bporch) + SW'(h_res)) > SW'(h_total)) |
                     ((SW'(v_sync) + SW'(v_bporch) + SW'(v_res)) > SW'(v_total)) |
                     (h_total == '0) | (v_total == '0);

  // Raster counters; shadow timing is reloaded only when a new frame begins.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_run         <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_frame_start <= 1'b0;
      r_h_total     <= '0;
      r_h_sync      <= '0;
      r_h_bporch    <= '0;
      r_h_res       <= '0;
      r_v_total     <= '0;
      r_v_sync      <= '0;
      r_v_bporch    <= '0;
      r_v_res       <= '0;
`ifdef LCD_TEST_PATTERN_EN
      r_tp          <= 1'b0;
`endif
    end else if (!enable) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_run         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      if (w_load) begin
        r_h_total  <= h_total;
        r_h_sync   <= h_sync;
        r_h_bporch <= h_bporch;
        r_h_res    <= h_res;
        r_v_total  <= v_total;
        r_v_sync   <= v_sync;
        r_v_bporch <= v_bporch;
        r_v_res    <= v_res;
        r_cfg_err  <= w_cfg_bad;
`ifdef LCD_TEST_PATTERN_EN
        r_tp       <= tp_sel;
`endif
      end
      if (!r_run) begin
        r_run   <= 1'b1;
        r_h_cnt <= '0;
        r_v_cnt <= '0;
      end else if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end
  end

  assign w_go      = enable & r_run & ~r_cfg_err;
  assign w_h_start = SW'(r_h_sync) + SW'(r_h_bporch);
  assign w_h_end   = w_h_start + SW'(r_h_res);
  assign w_v_start = SW'(r_v_sync) + SW'(r_v_bporch);
  assign w_v_end   = w_v_start + SW'(r_v_res);
  assign w_h_act   = (SW'(r_h_cnt) >= w_h_start) & (SW'(r_h_cnt) < w_h_end);
  assign w_v_act   = (SW'(r_v_cnt) >= w_v_start) & (SW'(r_v_cnt) < w_v_end);
  assign w_hs      = w_go & (r_h_cnt < r_h_sync);
  assign w_vs      = w_go & (r_v_cnt < r_v_sync);
  assign w_de      = w_go & w_h_act & w_v_act;
`ifdef LCD_TEST_PATTERN_EN
  assign w_rden    = w_de & ~r_tp;
`else
  assign w_rden    = w_de;
`endif

  // Sync/DE delay line; cleared at once when enable drops so the pins go idle quickly.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rden <= 1'b0;
      for (int i = 0; i < DL; i++) r_dl[i] <= '0;
    end else if (!enable) begin
      r_rden <= 1'b0;
      for (int i = 0; i < DL; i++) r_dl[i] <= '0;
    end else begin
      r_rden   <= w_rden;
      r_dl[0]  <= {w_hs, w_vs, w_de};
      for (int i = 1; i < DL; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) r_pix <= '0;
    else        r_pix <= fb_data;
  end

  generate
    if (IN_FMT == 0) begin : g_rgb565
      assign w_r8 = {r_pix[15:11], r_pix[15:13]};
      assign w_g8 = {r_pix[10:5],  r_pix[10:9]};
      assign w_b8 = {r_pix[4:0],   r_pix[4:2]};
    end else begin : g_rgb888
      assign w_r8 = r_pix[23:16];
      assign w_g8 = r_pix[15:8];
      assign w_b8 = r_pix[7:0];
    end
  endgenerate

`ifdef LCD_TEST_PATTERN_EN
  logic [CNT_W-1:0] r_bar_cnt, w_bar_w;
  logic [2:0]       r_bar, w_bar_rgb;
  logic [2:0]       r_bar_dl [DL];

  assign w_bar_w = r_h_res >> 3;

  // Bar index follows the DE pixel count; the last bar absorbs any remainder.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bar_cnt <= '0;
      r_bar     <= '0;
      for (int i = 0; i < DL; i++) r_bar_dl[i] <= '0;
    end else begin
      r_bar_dl[0] <= r_bar;
      for (int i = 1; i < DL; i++) r_bar_dl[i] <= r_bar_dl[i-1];
      if (!w_de) begin
        r_bar_cnt <= '0;
        r_bar     <= '0;
      end else if ((r_bar != 3'd7) && ((SW'(r_bar_cnt) + SW'(1)) >= SW'(w_bar_w))) begin
        r_bar_cnt <= '0;
        r_bar     <= r_bar + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_bar_rgb = 3'b000;
    case (r_bar_dl[DL-1])
      3'd0: w_bar_rgb = 3'b111;
      3'd1: w_bar_rgb = 3'b110;
      3'd2: w_bar_rgb = 3'b011;
      3'd3: w_bar_rgb = 3'b010;
      3'd4: w_bar_rgb = 3'b101;
      3'd5: w_bar_rgb = 3'b100;
      3'd6: w_bar_rgb = 3'b001;
      default: w_bar_rgb = 3'b000;
    endcase
  end

  assign w_sr8 = r_tp ? {8{w_bar_rgb[2]}} : w_r8;
  assign w_sg8 = r_tp ? {8{w_bar_rgb[1]}} : w_g8;
  assign w_sb8 = r_tp ? {8{w_bar_rgb[0]}} : w_b8;
`else
  assign w_sr8 = w_r8;
  assign w_sg8 = w_g8;
  assign w_sb8 = w_b8;
`endif

  generate
    if (OUT_BITS < 8) begin : g_trunc
      logic w_unused_lsb;
      assign w_unused_lsb = ^{w_sr8[7-OUT_BITS:0], w_sg8[7-OUT_BITS:0], w_sb8[7-OUT_BITS:0]};
    end
  endgenerate

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_o <= 1'b0;
      r_vs_o <= 1'b0;
      r_de_o <= 1'b0;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
    end else if (!enable) begin
      r_hs_o <= 1'b0;
      r_vs_o <= 1'b0;
      r_de_o <= 1'b0;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
    end else begin
      r_hs_o <= r_dl[DL-1][2];
      r_vs_o <= r_dl[DL-1][1];
      r_de_o <= r_dl[DL-1][0];
      r_r    <= r_dl[DL-1][0] ? w_sr8[7 -: OUT_BITS] : '0;
      r_g    <= r_dl[DL-1][0] ? w_sg8[7 -: OUT_BITS] : '0;
      r_b    <= r_dl[DL-1][0] ? w_sb8[7 -: OUT_BITS] : '0;
    end
  end

  // A new underflow event wins over a simultaneous clear.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n)                  r_underflow <= 1'b0;
    else if (r_rden & fb_empty)  r_underflow <= 1'b1;
    else if (underflow_clr)      r_underflow <= 1'b0;
  end

  assign fb_rden     = r_rden;
  assign lcd_hs      = r_hs_o ? hs_pol : ~hs_pol;
  assign lcd_vs      = r_vs_o ? vs_pol : ~vs_pol;
  assign lcd_de      = r_de_o;
  assign lcd_r       = r_r;
  assign lcd_g       = r_g;
  assign lcd_b       = r_b;
  assign frame_start = r_frame_start;
  assign cfg_err     = r_cfg_err;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_lcd_video_out.sv
// tb/tb_lcd_video_out.sv - directed self-checking bench for lcd_video_out
// Uses 480-pixel lines with a short 6-line frame to keep run time small.
module tb_lcd_video_out;
  localparam int RDL = 2;

  logic video_clk = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0;
  logic [15:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
  logic hs_pol, vs_pol, fb_empty, underflow_clr;
  logic [15:0] pix_val;
  logic [15:0] fb_data;
  logic [RDL-1:0] rd_pipe = '0;
`ifdef LCD_TEST_PATTERN_EN
  logic tp_sel = 1'b0;
`endif

  logic fb_rden, lcd_hs, lcd_vs, lcd_de, frame_start, cfg_err, underflow;
  logic [7:0] lcd_r, lcd_g, lcd_b;
  logic fb_rden5, lcd_hs5, lcd_vs5, lcd_de5, frame_start5, cfg_err5, underflow5;
  logic [4:0] lcd_r5, lcd_g5, lcd_b5;

  int n_chk = 0, n_pass = 0;
  int m_cyc, m_rden, m_de, m_lines, m_run, m_hs, m_vs, m_err;
  logic [23:0] m_pix0, m_pix59, m_pix60, m_pix420, m_pix479;

  always #5 video_clk = ~video_clk;

  // Frame-buffer model: data valid RDL cycles after fb_rden, garbage otherwise.
  always @(posedge video_clk) rd_pipe <= {rd_pipe[RDL-2:0], fb_rden};
  assign fb_data = rd_pipe[RDL-1] ? pix_val : 16'hDEAD;

  lcd_video_out dut (
    .video_clk(video_clk), .rst_n(rst_n), .enable(enable),
    .h_total(h_total), .h_sync(h_sync), .h_bporch(h_bporch), .h_res(h_res),
    .v_total(v_total), .v_sync(v_sync), .v_bporch(v_bporch), .v_res(v_res),
    .hs_pol(hs_pol), .vs_pol(vs_pol),
`ifdef LCD_TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .fb_rden(fb_rden), .fb_data(fb_data), .fb_empty(fb_empty),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .frame_start(frame_start), .cfg_err(cfg_err), .underflow(underflow),
    .underflow_clr(underflow_clr)
  );

  lcd_video_out #(.OUT_BITS(5)) dut5 (
    .video_clk(video_clk), .rst_n(rst_n), .enable(enable),
    .h_total(h_total), .h_sync(h_sync), .h_bporch(h_bporch), .h_res(h_res),
    .v_total(v_total), .v_sync(v_sync), .v_bporch(v_bporch), .v_res(v_res),
    .hs_pol(hs_pol), .vs_pol(vs_pol),
`ifdef LCD_TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .fb_rden(fb_rden5), .fb_data(fb_data), .fb_empty(fb_empty),
    .lcd_hs(lcd_hs5), .lcd_vs(lcd_vs5), .lcd_de(lcd_de5),
    .lcd_r(lcd_r5), .lcd_g(lcd_g5), .lcd_b(lcd_b5),
    .frame_start(frame_start5), .cfg_err(cfg_err5), .underflow(underflow5),
    .underflow_clr(underflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Measures one frame from a frame_start cycle up to (not including) the next one.
  task automatic measure(input int chg_at, input logic [15:0] chg_val);
    int guard, run;
    logic pde, phs, pvs;
    guard = 0;
    while (frame_start !== 1'b1 && guard < 5000) begin
      @(negedge video_clk);
      guard++;
    end
    check("meas_sync", guard < 5000, 1);
    m_cyc = 0; m_rden = 0; m_de = 0; m_lines = 0; m_run = 0; m_hs = 0; m_vs = 0;
    m_err = cfg_err;
    m_pix0 = '0; m_pix59 = '0; m_pix60 = '0; m_pix420 = '0; m_pix479 = '0;
    pde = lcd_de; phs = lcd_hs; pvs = lcd_vs; run = 0;
    do begin
      if (fb_rden) m_rden++;
      if (lcd_de) begin
        m_de++;
        if (!pde) begin m_lines++; run = 0; end
        if (m_lines == 1) begin
          case (run)
            0:   m_pix0   = {lcd_r, lcd_g, lcd_b};
            59:  m_pix59  = {lcd_r, lcd_g, lcd_b};
            60:  m_pix60  = {lcd_r, lcd_g, lcd_b};
            420: m_pix420 = {lcd_r, lcd_g, lcd_b};
            479: m_pix479 = {lcd_r, lcd_g, lcd_b};
            default: ;
          endcase
        end
        run++;
        if (run > m_run) m_run = run;
      end
      if (lcd_hs && !phs) m_hs++;
      if (lcd_vs && !pvs) m_vs++;
      pde = lcd_de; phs = lcd_hs; pvs = lcd_vs;
      if (m_cyc == chg_at) h_res = chg_val;
      @(negedge video_clk);
      m_cyc++;
    end while (frame_start !== 1'b1 && m_cyc < 5000);
  endtask

  task automatic wait_for(input string tag, input logic want_de, output int n);
    n = 0;
    while (((want_de ? lcd_de : fb_rden) !== 1'b1) && n < 5000) begin
      @(negedge video_clk);
      n++;
    end
    check(tag, n < 5000, 1);
  endtask

  initial begin
    int n;
    logic [23:0] pre_rgb;
    h_total = 16'd525; h_sync = 16'd41; h_bporch = 16'd2; h_res = 16'd480;
    v_total = 16'd6;   v_sync = 16'd1;  v_bporch = 16'd1; v_res = 16'd3;
    hs_pol = 1'b1; vs_pol = 1'b1; fb_empty = 1'b0; underflow_clr = 1'b0;
    pix_val = 16'hF800; enable = 1'b1;

    repeat (3) @(negedge video_clk);
    check("rst_hs", lcd_hs, 0);
    check("rst_vs", lcd_vs, 0);
    check("rst_de", lcd_de, 0);
    check("rst_rgb", {lcd_r, lcd_g, lcd_b}, 0);
    check("rst_rden", fb_rden, 0);
    check("rst_flags", {underflow, cfg_err, frame_start}, 0);

    rst_n = 1'b1;
    @(negedge video_clk);
    check("fs_first", frame_start, 1);

    // First read request: 2 lines + 43 pixels after frame_start, plus the rden register.
    n = 0;
    while (fb_rden !== 1'b1 && n < 5000) begin @(negedge video_clk); n++; end
    check("rden_first", n, 1094);
    n = 0;
    pre_rgb = '0;
    while (lcd_de !== 1'b1 && n < 20) begin
      pre_rgb = {lcd_r, lcd_g, lcd_b};
      @(negedge video_clk);
      n++;
    end
    check("de_lat", n, 4);
    check("blank_rgb", pre_rgb, 0);
    check("f800_rgb888", {lcd_r, lcd_g, lcd_b}, 24'hFF0000);
    check("f800_out5", {lcd_r5, lcd_g5, lcd_b5}, {5'h1F, 5'h00, 5'h00});

    pix_val = 16'h0841;
    repeat (6) @(negedge video_clk);
    check("0841_rgb", {lcd_r, lcd_g, lcd_b}, 24'h080808);

    fb_empty = 1'b1;
    @(negedge video_clk);
    fb_empty = 1'b0;
    check("uf_set", underflow, 1);
    repeat (3) @(negedge video_clk);
    check("uf_sticky", underflow, 1);
    underflow_clr = 1'b1;
    @(negedge video_clk);
    underflow_clr = 1'b0;
    check("uf_clr", underflow, 0);
    fb_empty = 1'b1; underflow_clr = 1'b1;
    @(negedge video_clk);
    fb_empty = 1'b0; underflow_clr = 1'b0;
    check("uf_set_wins", underflow, 1);
    underflow_clr = 1'b1;
    @(negedge video_clk);
    underflow_clr = 1'b0;

    measure(-1, 16'd0);
    check("f0_period", m_cyc, 3150);
    check("f0_rden", m_rden, 1440);
    check("f0_de", m_de, 1440);
    check("f0_lines", m_lines, 3);
    check("f0_run", m_run, 480);
    check("f0_hs", m_hs, 6);
    check("f0_vs", m_vs, 1);
    check("f0_pix", m_pix479, 24'h080808);

    measure(1500, 16'd400);
    check("f1_de_keep", m_de, 1440);
    check("f1_run_keep", m_run, 480);
    measure(100, 16'd600);
    check("f2_de_new", m_de, 1200);
    check("f2_rden_new", m_rden, 1200);
    check("f2_run_new", m_run, 400);
    measure(100, 16'd480);
    check("f3_err", m_err, 1);
    check("f3_de", m_de, 0);
    check("f3_rden", m_rden, 0);
    check("f3_hs", m_hs, 0);
    check("f3_period", m_cyc, 3150);
    measure(-1, 16'd0);
    check("f4_err", m_err, 0);
    check("f4_de", m_de, 1440);

    wait_for("wait_rden", 1'b0, n);
    repeat (10) @(negedge video_clk);
    enable = 1'b0;
    @(negedge video_clk);
    check("dis_rden", fb_rden, 0);
    check("dis_de", lcd_de, 0);
    check("dis_hs", lcd_hs, 0);
    hs_pol = 1'b0;
    #1;
    check("hs_pol_lo", lcd_hs, 1);
    hs_pol = 1'b1;
    repeat (3) @(negedge video_clk);
    check("dis_fs", frame_start, 0);
    enable = 1'b1;
    @(negedge video_clk);
    check("en_fs", frame_start, 1);

    wait_for("wait_de", 1'b1, n);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", {lcd_de, fb_rden, lcd_r, lcd_g, lcd_b}, 0);
    @(negedge video_clk);
    rst_n = 1'b1;
    @(negedge video_clk);
    check("arst_fs", frame_start, 1);

`ifdef LCD_TEST_PATTERN_EN
    tp_sel = 1'b1;
    measure(-1, 16'd0);
    measure(-1, 16'd0);
    check("tp_rden", m_rden, 0);
    check("tp_de", m_de, 1440);
    check("tp_pix0", m_pix0, 24'hFFFFFF);
    check("tp_pix59", m_pix59, 24'hFFFFFF);
    check("tp_pix60", m_pix60, 24'hFFFF00);
    check("tp_pix420", m_pix420, 24'h000000);
    check("tp_pix479", m_pix479, 24'h000000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
